// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM state encoding and the memory word size.
package mau_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/mem_access_unit.sv
// Load/store front end for the data memory: one word access per request, response held until accepted.
// Optional macro MEM_ACCESS_ADDR_CHECK_EN flags misaligned or out-of-range addresses instead of wrapping them.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int          ADDR_W    = 11,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              flush,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_ena,
    output logic              mem_wea,
    output logic [ADDR_W-1:0] mem_addra,
    output logic [DATA_W-1:0] mem_dina,
    input  logic [DATA_W-1:0] mem_douta,
    output logic [CNT_W-1:0]  ld_count,
    output logic [CNT_W-1:0]  st_count
);

    localparam int OFF_W = $clog2(WORD_BYTES);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    ld_count_q, ld_count_d;
    logic [CNT_W-1:0]    st_count_q, st_count_d;

    logic [31:0]         offset;
    logic                req_err;
    logic                issue_ena;

    assign offset = req_addr - BASE_ADDR;

`ifdef MEM_ACCESS_ADDR_CHECK_EN
    assign req_err = (req_addr[OFF_W-1:0] != '0) || ((offset >> (ADDR_W + OFF_W)) != 32'd0);
`else
    // Byte-lane and upper offset bits are deliberately ignored so addresses wrap.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{offset[31:ADDR_W+OFF_W], offset[OFF_W-1:0]};
    assign req_err = 1'b0;
`endif

    assign issue_ena = (state_q == ISSUE) && !err_q;

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        err_d      = err_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rsp_err_d  = rsp_err_q;
        ld_count_d = ld_count_q;
        st_count_d = st_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    we_d    = req_we;
                    err_d   = req_err;
                    addr_d  = offset[ADDR_W+OFF_W-1:OFF_W];
                    wdata_d = req_wdata;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // Memory already acted on the falling edge; a flush only drops the response.
                rdata_d   = (we_q || err_q) ? '0 : mem_douta;
                rsp_err_d = err_q;
                state_d   = flush ? IDLE : RESP;
            end
            RESP: begin
                if (rsp_ready || flush) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (issue_ena && !we_q && (ld_count_q != '1)) ld_count_d = ld_count_q + CNT_W'(1);
        if (issue_ena &&  we_q && (st_count_q != '1)) st_count_d = st_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rsp_err_q  <= 1'b0;
            ld_count_q <= '0;
            st_count_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            rsp_err_q  <= rsp_err_d;
            ld_count_q <= ld_count_d;
            st_count_q <= st_count_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = (state_q == RESP) ? rdata_q : '0;
    assign rsp_err   = (state_q == RESP) && rsp_err_q;
    assign mem_ena   = issue_ena;
    assign mem_wea   = issue_ena && we_q;
    assign mem_addra = (state_q == ISSUE) ? addr_q : '0;
    assign mem_dina  = (state_q == ISSUE) ? wdata_q : '0;
    assign ld_count  = ld_count_q;
    assign st_count  = st_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit against a word-array reference model and a falling-edge memory.
// Honours MEM_ACCESS_ADDR_CHECK_EN when the design is built with it.
module tb_mem_access_unit;

    localparam int MEM_WORDS = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        flush = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_ena;
    logic        mem_wea;
    logic [10:0] mem_addra;
    logic [31:0] mem_dina;
    logic [31:0] mem_douta = '0;
    logic [15:0] ld_count;
    logic [15:0] st_count;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] tb_mem  [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int exp_ld = 0;
    int exp_st = 0;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta),
        .ld_count(ld_count), .st_count(st_count)
    );

    always #5 clk = ~clk;

    // Block RAM stand-in: read-first, acts on the falling edge.
    always @(negedge clk) begin
        if (mem_ena) begin
            if (mem_wea) tb_mem[mem_addra] <= mem_dina;
            mem_douta <= tb_mem[mem_addra];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        n_cmp++;
        if (ld_count !== 16'(exp_ld) || st_count !== 16'(exp_st)) begin
            n_fail++;
            $display("[TB] FAIL %s counts: got ld=%0d st=%0d want ld=%0d st=%0d", tag, ld_count, st_count, exp_ld, exp_st);
        end
    endtask

    task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input int hold, input bit flush_issue, input bit next_waiting);
        int word;
        bit err;
        logic [31:0] exp_rd;
        word = int'((addr / 4) % MEM_WORDS);
        err = 1'b0;
`ifdef MEM_ACCESS_ADDR_CHECK_EN
        err = (addr % 4 != 0) || ((addr / 4) >= MEM_WORDS);
`endif
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_ready: got ready=%b valid=%b want 1/0", req_ready, rsp_valid);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;

        n_cmp++;
        if (mem_ena !== !err || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL issue_ctrl addr=%h: got ena=%b ready=%b valid=%b want ena=%b 0 0", addr, mem_ena, req_ready, rsp_valid, !err);
        end
        if (!err) begin
            n_cmp++;
            if (mem_addra !== 11'(word) || mem_wea !== we || (we && mem_dina !== wdata)) begin
                n_fail++;
                $display("[TB] FAIL issue_port addr=%h: got a=%0d we=%b d=%h want a=%0d we=%b d=%h", addr, mem_addra, mem_wea, mem_dina, word, we, wdata);
            end
            if (we) begin
                ref_mem[word] = wdata;
                if (exp_st < 65535) exp_st++;
            end else if (exp_ld < 65535) exp_ld++;
        end
        exp_rd = (we || err) ? 32'h0 : ref_mem[word];

        if (flush_issue) flush = 1'b1;
        tick();
        flush = 1'b0;
        if (flush_issue) begin
            n_cmp++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL flush_issue: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
            end
            check_counts("flush_issue");
            return;
        end

        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || rsp_err !== err || req_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL resp addr=%h: got v=%b d=%h e=%b r=%b want 1 %h %b 0", addr, rsp_valid, rsp_rdata, rsp_err, req_ready, exp_rd, err);
        end
        if (next_waiting) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0014;
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd || req_ready !== 1'b0 || mem_ena !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL hold%0d: got v=%b d=%h r=%b ena=%b want 1 %h 0 0", i, rsp_valid, rsp_rdata, req_ready, mem_ena, exp_rd);
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_ena !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL release: got v=%b r=%b ena=%b want 0 1 0", rsp_valid, req_ready, mem_ena);
        end
        check_counts("release");
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== '0 || rsp_err !== 1'b0 ||
            mem_ena !== 1'b0 || mem_wea !== 1'b0 || mem_addra !== '0 || mem_dina !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got r=%b v=%b d=%h e=%b ena=%b we=%b a=%h di=%h", req_ready, rsp_valid, rsp_rdata, rsp_err, mem_ena, mem_wea, mem_addra, mem_dina);
        end
        check_counts("reset");
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load();
        tb_mem[5] = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        do_access(1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_store_load();
        do_access(1'b1, 32'h1FFC, 32'hCAFEF00D, 0, 1'b0, 1'b0);
        do_access(1'b0, 32'h1FFC, 32'h0, 1, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_access(1'b0, 32'h1FFC, 32'h0, 4, 1'b0, 1'b1);
        do_access(1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h1234_5678; flush = 1'b1;
        tick();
        req_valid = 1'b0; req_we = 1'b0; flush = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || mem_ena !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL flush_idle: got ready=%b ena=%b want 1/0", req_ready, mem_ena);
        end
        do_access(1'b1, 32'h40, 32'hA5A5_0F0F, 0, 1'b1, 1'b0);
        do_access(1'b0, 32'h40, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        do_access(1'b0, 32'h2000, 32'h0, 0, 1'b0, 1'b0);
        do_access(1'b0, 32'h2002, 32'h0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic        w;
            a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'h1FFF));
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            w = 1'($urandom_range(0, 1));
            do_access(w, a, $urandom(), int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), 1'b0);
        end
    endtask

    task automatic test_reset_mid_resp();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h14;
        tick();
        req_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_ld = 0; exp_st = 0;
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_resp: got v=%b r=%b want 0/1", rsp_valid, req_ready);
        end
        check_counts("reset_mid_resp");
        tick();
        rst_n = 1'b1;
        tick();
        do_access(1'b0, 32'h14, 32'h0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            tb_mem[i]  = $urandom();
            ref_mem[i] = tb_mem[i];
        end
        test_reset();
        test_load();
        test_store_load();
        test_backpressure();
        test_flush();
        test_wrap();
        test_random();
        test_reset_mid_resp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
